star_hub_router: RTL

Parametrised central hub router for the star NoC, the next generation of the fixed 10-port, 8-bit hub.
- Port count, flit width and buffer depth are parameters.
- The global Write/Read strobes are replaced by per-port valid/ready handshakes.
- Each input port has a FIFO; each output port has a round-robin arbiter and a registered output stage.
- Sits at the star centre; each leaf router connects to one port pair through registered links.

---
 rtl/star_hub_router_pkg.sv | 40 ++++
 rtl/star_hub_router_if.sv | 15 +
 rtl/star_hub_router_fifo.sv | 42 ++++
 rtl/star_hub_router.sv | 133 +++++++++++++
 4 files changed

// File: rtl/star_hub_router_pkg.sv
// Shared constants and helpers for the star hub router: field slicing,
// pointer sizing and the round-robin priority select used by every output.
package star_pkg;

  localparam int DATAWID_DEF = 8;
  localparam int DESTW_DEF   = 4;
  localparam int DEPTH_DEF   = 4;
  localparam int MAXP        = 16;
  localparam int PTRW_DEF    = $clog2(DEPTH_DEF) + 1;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Destination index sits in the top DESTW bits of the flit.
  function automatic logic [7:0] dest_of(input logic [63:0] flit, input int datawid,
                                         input int destw);
    return 8'((flit >> (datawid - destw)) & ((64'd1 << destw) - 64'd1));
  endfunction

  function automatic logic [MAXP-1:0] rr_pick(input logic [MAXP-1:0] req,
                                              input logic [3:0] ptr,
                                              input int unsigned n);
    logic [MAXP-1:0] gnt;
    logic            found;
    int unsigned     idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAXP; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if ((i < n) && !found && req[idx[3:0]]) begin
        gnt[idx[3:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/star_hub_router_if.sv
// Per-port valid/ready flit bundle between the hub and its leaf links.
interface star_hub_router_if #(
  parameter int NPORTS  = 10,
  parameter int DATAWID = 8
);
  logic [NPORTS*DATAWID-1:0] in_data;
  logic [NPORTS-1:0]         in_valid;
  logic [NPORTS-1:0]         in_ready;
  logic [NPORTS*DATAWID-1:0] out_data;
  logic [NPORTS-1:0]         out_valid;
  logic [NPORTS-1:0]         out_ready;

  modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
endinterface

// File: rtl/star_hub_router_fifo.sv
// Per-input flit FIFO; pointers carry one extra wrap bit so full and empty
// are told apart without an occupancy counter.
module hub_fifo
  import star_pkg::*;
#(
  parameter int DATAWID = DATAWID_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [DATAWID-1:0] i_data,
  output logic [DATAWID-1:0] o_head,
  output logic               o_full,
  output logic               o_empty
);
  localparam int PTRW = ptr_width(DEPTH);

  logic [DATAWID-1:0] r_mem [DEPTH];
  logic [PTRW-1:0]    r_wp;
  logic [PTRW-1:0]    r_rp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + PTRW'(1);
      if (i_pop)  r_rp <= r_rp + PTRW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp[PTRW-2:0]] <= i_data;
  end

  assign o_head  = r_mem[r_rp[PTRW-2:0]];
  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[PTRW-1] != r_rp[PTRW-1]) && (r_wp[PTRW-2:0] == r_rp[PTRW-2:0]);

endmodule

// File: rtl/star_hub_router.sv
// Star NoC centre: one FIFO per input, one round-robin arbiter and registered
// output stage per output, plus a saturating counter of bad-destination drops.
module star_hub_router
  import star_pkg::*;
#(
  parameter int NPORTS  = 10,
  parameter int DATAWID = DATAWID_DEF,
  parameter int DESTW   = DESTW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int CNTW    = 16
) (
  input  logic              clk,
  input  logic              rst,
  star_hub_router_if.slave  bus,
  output logic [NPORTS-1:0] drop_pulse,
  output logic [CNTW-1:0]   drop_count
);
  localparam int PW = 4;
  localparam int SW = CNTW + 5;

  logic               r_rdy_en;
  logic [NPORTS-1:0]  w_push, w_pop, w_full, w_empty, w_bad, w_load;
  logic [DATAWID-1:0] w_head [NPORTS];
  logic [7:0]         w_dest [NPORTS];
  logic [NPORTS-1:0]  w_req  [NPORTS];
  logic [NPORTS-1:0]  w_gnt  [NPORTS];
  logic [DATAWID-1:0] w_sel  [NPORTS];
  logic [PW-1:0]      w_nxt  [NPORTS];
  logic [PW-1:0]      r_rr   [NPORTS];
  logic [DATAWID-1:0] r_odata [NPORTS];
  logic [NPORTS-1:0]  r_ovalid;
  logic [CNTW-1:0]    r_cnt;
  logic [CNTW-1:0]    w_cnt_nxt;
  logic [4:0]         w_ndrop;
  logic [SW-1:0]      w_sum;

  // Held low through reset so no flit is taken before the first clean edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rdy_en <= 1'b0;
    else      r_rdy_en <= 1'b1;
  end

  assign bus.in_ready = r_rdy_en ? ~w_full : '0;

  for (genvar p = 0; p < NPORTS; p++) begin : g_in
    assign w_push[p] = bus.in_valid[p] & bus.in_ready[p];
    hub_fifo #(.DATAWID(DATAWID), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[p]),
      .i_pop   (w_pop[p]),
      .i_data  (bus.in_data[p*DATAWID +: DATAWID]),
      .o_head  (w_head[p]),
      .o_full  (w_full[p]),
      .o_empty (w_empty[p])
    );
    assign w_dest[p] = dest_of(64'(w_head[p]), DATAWID, DESTW);
    assign w_bad[p]  = !w_empty[p] && (32'(w_dest[p]) >= 32'(NPORTS));
  end

  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      w_req[o] = '0;
      for (int g = 0; g < NPORTS; g++)
        w_req[o][g] = !w_empty[g] && (w_dest[g] == 8'(o));
    end
  end

  for (genvar o = 0; o < NPORTS; o++) begin : g_out
    logic [MAXP-1:0] w_pick;
    assign w_pick    = rr_pick(MAXP'(w_req[o]), r_rr[o], NPORTS);
    assign w_load[o] = !r_ovalid[o] | bus.out_ready[o];
    assign w_gnt[o]  = w_load[o] ? NPORTS'(w_pick) : '0;
    assign bus.out_data[o*DATAWID +: DATAWID] = r_odata[o];
  end

  // An input requests exactly one output, so at most one grant hits each FIFO.
  always_comb begin
    w_pop = w_bad;
    for (int o = 0; o < NPORTS; o++) w_pop = w_pop | w_gnt[o];
  end

  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      w_sel[o] = '0;
      w_nxt[o] = r_rr[o];
      for (int g = 0; g < NPORTS; g++) begin
        if (w_gnt[o][g]) begin
          w_sel[o] = w_head[g];
          w_nxt[o] = (g == NPORTS - 1) ? '0 : PW'(g + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovalid <= '0;
      for (int o = 0; o < NPORTS; o++) begin
        r_odata[o] <= '0;
        r_rr[o]    <= '0;
      end
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        if (w_gnt[o] != '0) begin
          r_odata[o]  <= w_sel[o];
          r_ovalid[o] <= 1'b1;
          r_rr[o]     <= w_nxt[o];
        end else if (bus.out_ready[o]) begin
          r_ovalid[o] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_ndrop = '0;
    for (int p = 0; p < NPORTS; p++) w_ndrop = w_ndrop + 5'(w_bad[p]);
    w_sum = SW'(r_cnt) + SW'(w_ndrop);
    if (|w_sum[SW-1:CNTW]) w_cnt_nxt = '1;
    else                   w_cnt_nxt = w_sum[CNTW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= '0;
    else      r_cnt <= w_cnt_nxt;
  end

  assign bus.out_valid = r_ovalid;
  assign drop_pulse    = w_bad;
  assign drop_count    = r_cnt;

endmodule
